// File: rtl/host_wr_capture.sv
// host_wr_capture
// ----------------
// Host-side capture stage feeding the VRAM write port. Samples the
// asynchronous host memory bus into the dot-clock domain, rejects strobe
// glitches shorter than MIN_LOW synchronized samples, keeps a 2-bit bank
// register and issues one single-cycle VRAM write per completed host write.
//
// Parameters:
//   MIN_LOW        synchronized low samples needed for a real cycle (1..7)
//
// Ports:
//   clk            dot clock
//   rst            synchronous, active-high reset
//   hostBusAddr    host address A10..A0 (async, sampled while strobe low)
//   hostBusDataIn  host data (async, sampled while strobe low)
//   nHostWMEM      host write strobe, active low
//   nHostRMEM      host read strobe, active low
//   nHostVRAMEn    VRAM window select, active low
//   nHostBankRegEn bank register select, active low
//   hostWrAddr     VRAM write address {bank, addr}, holds between pulses
//   hostWrData     VRAM write data, holds between pulses
//   hostWr         one-cycle VRAM write enable
//   bankReg        current bank register
//   hostBusDir     1 = host drives the bus, 0 = FPGA drives
//   hostRdData     data driven onto the bus when hostBusDir = 0
//
// Optional feature: define HOST_BANK_READBACK_EN to let the host read the
// bank register back. Without it the bus is always an input.

module host_wr_capture #(
   parameter int MIN_LOW = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] hostBusAddr,
   input  logic [7:0]  hostBusDataIn,
   input  logic        nHostWMEM,
   input  logic        nHostRMEM,
   input  logic        nHostVRAMEn,
   input  logic        nHostBankRegEn,
   output logic [12:0] hostWrAddr,
   output logic [7:0]  hostWrData,
   output logic        hostWr,
   output logic [1:0]  bankReg,
   output logic        hostBusDir,
   output logic [7:0]  hostRdData
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      HELD  = 2'd2
   } stateT;

   localparam logic [2:0] MinLow = 3'(MIN_LOW);

   stateT       state;
   stateT       nextState;
   logic [2:0]  lowCnt;
   logic [2:0]  nextLowCnt;
   logic        captureEn;
   logic        commitEn;

   logic        wrSync1, wrSync2;
   logic        rdSync1, rdSync2;
   logic        vramSync1, vramSync2;
   logic        bankSync1, bankSync2;

   // After reset the synchronizers still hold their idle-high reset values,
   // so a real high sample can only be trusted once the pipe has refilled.
   logic [1:0]  syncFill;
   logic        needHigh;

   logic [10:0] capAddr;
   logic [7:0]  capData;
   logic        capNVram;
   logic        capNBank;
   logic [1:0]  capBank;

   // The read-strobe synchronizer exists for symmetry with the other strobes
   // but no registered logic consumes it; the readback path uses the pins.
   logic        unusedRdSync;
   assign unusedRdSync = rdSync2;

   // Cycle qualification FSM: counts synchronized low samples, captures the
   // bus on every low sample so the last one wins, and requests a commit on
   // the first high sample after the cycle was qualified.
   always_comb begin
      nextState  = state;
      nextLowCnt = lowCnt;
      captureEn  = 1'b0;
      commitEn   = 1'b0;
      case (state)
         IDLE: begin
            if (!wrSync2 && !needHigh) begin
               captureEn  = 1'b1;
               nextLowCnt = 3'd1;
               nextState  = (MinLow == 3'd1) ? HELD : COUNT;
            end
         end
         COUNT: begin
            if (!wrSync2) begin
               captureEn  = 1'b1;
               nextLowCnt = lowCnt + 3'd1;
               if (lowCnt + 3'd1 == MinLow) begin
                  nextState = HELD;
               end
            end else begin
               nextState  = IDLE;
               nextLowCnt = 3'd0;
            end
         end
         HELD: begin
            if (!wrSync2) begin
               captureEn = 1'b1;
            end else begin
               commitEn   = 1'b1;
               nextState  = IDLE;
               nextLowCnt = 3'd0;
            end
         end
         default: begin
            nextState  = IDLE;
            nextLowCnt = 3'd0;
         end
      endcase
   end

   // Synchronizers, state register, holding registers and commit decode.
   // A commit writes VRAM only when exactly the VRAM window was selected and
   // writes the bank register only when exactly the bank select was active.
   always_ff @(posedge clk) begin
      if (rst) begin
         wrSync1    <= 1'b1;
         wrSync2    <= 1'b1;
         rdSync1    <= 1'b1;
         rdSync2    <= 1'b1;
         vramSync1  <= 1'b1;
         vramSync2  <= 1'b1;
         bankSync1  <= 1'b1;
         bankSync2  <= 1'b1;
         syncFill   <= 2'd0;
         needHigh   <= 1'b1;
         state      <= IDLE;
         lowCnt     <= 3'd0;
         capAddr    <= 11'd0;
         capData    <= 8'd0;
         capNVram   <= 1'b1;
         capNBank   <= 1'b1;
         capBank    <= 2'd0;
         hostWr     <= 1'b0;
         hostWrAddr <= 13'd0;
         hostWrData <= 8'd0;
         bankReg    <= 2'd0;
      end else begin
         wrSync1   <= nHostWMEM;
         wrSync2   <= wrSync1;
         rdSync1   <= nHostRMEM;
         rdSync2   <= rdSync1;
         vramSync1 <= nHostVRAMEn;
         vramSync2 <= vramSync1;
         bankSync1 <= nHostBankRegEn;
         bankSync2 <= bankSync1;

         if (syncFill != 2'd2) begin
            syncFill <= syncFill + 2'd1;
         end else if (wrSync2) begin
            needHigh <= 1'b0;
         end

         state  <= nextState;
         lowCnt <= nextLowCnt;
         hostWr <= 1'b0;

         if (captureEn) begin
            capAddr  <= hostBusAddr;
            capData  <= hostBusDataIn;
            capNVram <= vramSync2;
            capNBank <= bankSync2;
            capBank  <= bankReg;
         end

         if (commitEn) begin
            if (!capNVram && capNBank) begin
               hostWr     <= 1'b1;
               hostWrAddr <= {capBank, capAddr};
               hostWrData <= capData;
            end else if (capNVram && !capNBank) begin
               bankReg <= capData[1:0];
            end
         end
      end
   end

`ifdef HOST_BANK_READBACK_EN
   logic [7:0] rdDataReg;

   // Bank readback: the bus turns around directly from the pins so the host
   // sees data within its own read cycle; VRAM reads never turn it around.
   assign hostBusDir = nHostRMEM | nHostBankRegEn;

   always_ff @(posedge clk) begin
      if (rst) begin
         rdDataReg <= 8'd0;
      end else begin
         rdDataReg <= {6'b0, bankReg};
      end
   end

   assign hostRdData = rdDataReg;
`else
   assign hostBusDir = 1'b1;
   assign hostRdData = 8'd0;
`endif

endmodule
